// File: rtl/lfsr_step_engine_if.sv
// Command/status bundle between a controller and the LFSR step engine.
// The controller drives the seed and step commands; the engine returns
// its state word, the serial bit and its status flags.
interface lfsr_step_engine_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic             start;
   logic [CNT_W-1:0] num_steps;
   logic             step_en;
   logic [WIDTH-1:0] state_out;
   logic             ser_out;
   logic             busy;
   logic             done;
   logic             lockup;
   logic             period_hit;

   modport master (
      output seed_load, seed, start, num_steps, step_en,
      input  state_out, ser_out, busy, done, lockup, period_hit
   );

   modport slave (
      input  seed_load, seed, start, num_steps, step_en,
      output state_out, ser_out, busy, done, lockup, period_hit
   );
endinterface

// File: rtl/lfsr_step_engine.sv
// Loadable Fibonacci LFSR with a run-N-steps burst FSM.
// In IDLE it accepts a seed load, a burst start or single steps. In RUN it
// shifts once per cycle until the burst count is used up, or until a seed
// load aborts the burst. done and period_hit are one-cycle pulses.
module lfsr_step_engine #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(8'h01),
   parameter int               CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   lfsr_step_engine_if.slave    ctl_io
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fsm_t;

   fsm_t             fsm_q;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] seed_q;
   logic [CNT_W-1:0] rem_q;
   logic             busy_q;
   logic             done_q;
   logic             phit_q;

   logic [WIDTH-1:0] shift_d;
   logic             lockup_d;

   // Next LFSR value: shift left, feedback is the parity of the tapped bits.
   assign shift_d  = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
   assign lockup_d = (state_q == '0);

   // Command FSM, LFSR state and registered status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= RESET_SEED;
         seed_q  <= RESET_SEED;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         phit_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         phit_q <= 1'b0;
         unique case (fsm_q)
            ST_IDLE: begin
               if (ctl_io.seed_load) begin
                  state_q <= ctl_io.seed;
                  seed_q  <= ctl_io.seed;
               end else if (ctl_io.start && lockup_d) begin
                  // a stuck all-zero state cannot be run; drop the request
               end else if (ctl_io.start && (ctl_io.num_steps == '0)) begin
                  done_q <= 1'b1;
               end else if (ctl_io.start) begin
                  rem_q  <= ctl_io.num_steps;
                  fsm_q  <= ST_RUN;
                  busy_q <= 1'b1;
               end else if (ctl_io.step_en) begin
                  state_q <= shift_d;
                  phit_q  <= (shift_d == seed_q);
               end
            end
            ST_RUN: begin
               if (ctl_io.seed_load) begin
                  state_q <= ctl_io.seed;
                  seed_q  <= ctl_io.seed;
                  rem_q   <= '0;
                  fsm_q   <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= shift_d;
                  phit_q  <= (shift_d == seed_q);
                  rem_q   <= rem_q - 1'b1;
                  if (rem_q == CNT_W'(1)) begin
                     fsm_q  <= ST_IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               fsm_q  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign ctl_io.state_out  = state_q;
   assign ctl_io.ser_out    = state_q[WIDTH-1];
   assign ctl_io.busy       = busy_q;
   assign ctl_io.done       = done_q;
   assign ctl_io.lockup     = lockup_d;
   assign ctl_io.period_hit = phit_q;

endmodule
